bitblt_mul_pipe: RTL

// - Parametrised, pipelined multiplier for the bitblt datapath (address/stride and pixel-scale products).
// - Full valid/ready backpressure, per-transaction signed/unsigned operands, optional saturation,

---
 rtl/bitblt_mul_pkg.sv | 30 +++
 rtl/bitblt_mul_pipe_stage.sv | 44 ++++
 rtl/bitblt_mul_pipe.sv | 105 ++++++++++
 3 files changed

// File: rtl/bitblt_mul_pkg.sv
// rtl/bitblt_mul_pkg.sv - shared widths and range-limit helpers for the bitblt multiplier
package bitblt_mul_pkg;

    localparam int MAX_NUM_STAGE = 4;
    // Wide enough to hold any product and any DOUT range limit.
    localparam int LIM_W = 128;

    function automatic int prod_width(input int w0, input int w1);
        return w0 + w1 + 2;
    endfunction

    function automatic logic signed [LIM_W-1:0] min_val(input int d, input logic is_signed);
        logic signed [LIM_W-1:0] one;
        one = 1;
        if (is_signed) begin
            return -(one <<< (d - 1));
        end
        return '0;
    endfunction

    function automatic logic signed [LIM_W-1:0] max_val(input int d, input logic is_signed);
        logic signed [LIM_W-1:0] one;
        one = 1;
        if (is_signed) begin
            return (one <<< (d - 1)) - one;
        end
        return (one <<< d) - one;
    endfunction

endpackage

// File: rtl/bitblt_mul_pipe_stage.sv
// rtl/bitblt_mul_pipe_stage.sv - one valid/ready register slice over a generic payload
module bitblt_mul_pipe_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    // Loads when empty or when the current beat leaves this cycle.
    assign in_ready  = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (in_ready) begin
            valid_d = in_valid;
        end
        if (in_valid && in_ready) begin
            data_d = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/bitblt_mul_pipe.sv
// rtl/bitblt_mul_pipe.sv - pipelined signed/unsigned multiplier with saturation, overflow and tag
module bitblt_mul_pipe
    import bitblt_mul_pkg::*;
#(
    parameter int DIN0_WIDTH = 17,
    parameter int DIN1_WIDTH = 19,
    parameter int DOUT_WIDTH = 35,
    parameter int NUM_STAGE  = 3,
    parameter int SATURATE   = 0,
    parameter int TAG_WIDTH  = 8
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    input  logic                  din0_signed,
    input  logic                  din1_signed,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic                  out_ovf,
    output logic [TAG_WIDTH-1:0]  out_tag
);

    localparam int PW   = prod_width(DIN0_WIDTH, DIN1_WIDTH);
    localparam int MIDW = PW + 1 + TAG_WIDTH;
    localparam int OUTW = DOUT_WIDTH + 1 + TAG_WIDTH;
    localparam int NMID = (NUM_STAGE > 0) ? NUM_STAGE : 1;

    logic signed [PW-1:0] op0_ext, op1_ext, prod;

    // Extending straight to PW makes the product exact and avoids width games in the multiply.
    assign op0_ext = {{(PW-DIN0_WIDTH){din0_signed & din0[DIN0_WIDTH-1]}}, din0};
    assign op1_ext = {{(PW-DIN1_WIDTH){din1_signed & din1[DIN1_WIDTH-1]}}, din1};
    assign prod    = op0_ext * op1_ext;

    logic [MIDW-1:0] mid_data  [NMID];
    logic            mid_valid [NMID];
    logic            mid_ready [NMID];

    assign mid_data[0]  = {prod, din0_signed | din1_signed, in_tag};
    assign mid_valid[0] = in_valid;
    assign in_ready     = mid_ready[0];

    for (genvar k = 0; k < NUM_STAGE - 1; k++) begin : g_mid
        bitblt_mul_pipe_stage #(.WIDTH(MIDW)) u_stage (
            .clk       (ap_clk),
            .rst_n     (ap_rst_n),
            .in_valid  (mid_valid[k]),
            .in_ready  (mid_ready[k]),
            .in_data   (mid_data[k]),
            .out_valid (mid_valid[k+1]),
            .out_ready (mid_ready[k+1]),
            .out_data  (mid_data[k+1])
        );
    end

    logic [MIDW-1:0]             mid_last;
    logic signed [PW-1:0]        p_last;
    logic                        sgn_last;
    logic [TAG_WIDTH-1:0]        tag_last;
    logic signed [LIM_W-1:0]     p_wide, lim_lo, lim_hi;
    logic                        under, over;
    logic [DOUT_WIDTH-1:0]       clamp_dout;
    logic [OUTW-1:0]             last_in, last_out;

    assign mid_last = mid_data[NMID-1];
    assign p_last   = mid_last[MIDW-1 -: PW];
    assign sgn_last = mid_last[TAG_WIDTH];
    assign tag_last = mid_last[TAG_WIDTH-1:0];

    // Range check happens just ahead of the final register.
    assign p_wide = {{(LIM_W-PW){p_last[PW-1]}}, p_last};
    assign lim_lo = min_val(DOUT_WIDTH, sgn_last);
    assign lim_hi = max_val(DOUT_WIDTH, sgn_last);
    assign under  = p_wide < lim_lo;
    assign over   = p_wide > lim_hi;

    assign clamp_dout = DOUT_WIDTH'(((SATURATE != 0) && under) ? lim_lo :
                                    ((SATURATE != 0) && over)  ? lim_hi : p_wide);
    assign last_in    = {clamp_dout, under | over, tag_last};

    if (NUM_STAGE > 0) begin : g_last
        bitblt_mul_pipe_stage #(.WIDTH(OUTW)) u_stage (
            .clk       (ap_clk),
            .rst_n     (ap_rst_n),
            .in_valid  (mid_valid[NMID-1]),
            .in_ready  (mid_ready[NMID-1]),
            .in_data   (last_in),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .out_data  (last_out)
        );
    end else begin : g_comb
        assign out_valid    = mid_valid[0];
        assign mid_ready[0] = out_ready;
        assign last_out     = last_in;
    end

    assign {dout, out_ovf, out_tag} = last_out;

endmodule
